// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: sequential fetch from a combinational ROM into a small FIFO.
// Optional redirect target checking is enabled with the FETCH_ALIGN_CHECK_EN macro.
module imem_fetch_ctrl #(
  parameter int unsigned MEM_BYTES = 1024,
  parameter logic [63:0] RESET_PC  = 64'd0,
  parameter int unsigned QDEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  output logic        halted,
  output logic        align_err,
  output logic [31:0] fetch_cnt
);

  localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t             q_mem [QDEPTH];

  logic [63:0]        fetch_pc_q,  fetch_pc_d;
  logic [PTR_W-1:0]   head_q,      head_d;
  logic [PTR_W-1:0]   tail_q,      tail_d;
  logic [CNT_W-1:0]   count_q,     count_d;
  logic               halted_q,    halted_d;
  logic               align_err_q, align_err_d;
  logic [31:0]        fetch_cnt_q, fetch_cnt_d;

  logic               out_of_range;
  logic               redirect_bad;
  logic [63:0]        target_pc;
  logic               push;
  logic               pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Widened compare so the last-byte test cannot wrap near the top of the address space.
  assign out_of_range = (({1'b0, fetch_pc_q} + 65'd3) >= 65'(MEM_BYTES));
  assign target_pc    = {redirect_pc[63:2], 2'b00};

`ifdef FETCH_ALIGN_CHECK_EN
  assign redirect_bad = (redirect_pc[1:0] != 2'b00) ||
                        (({1'b0, redirect_pc} + 65'd3) >= 65'(MEM_BYTES));
`else
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign redirect_bad        = 1'b0;
`endif

  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready && !redirect;
  assign push      = !redirect && !halted_q && !out_of_range &&
                     ((count_q < CNT_W'(QDEPTH)) || pop);

  // Next-state logic; a redirect overrides any push or pop on the same edge.
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    halted_d    = halted_q;
    align_err_d = align_err_q;
    fetch_cnt_d = fetch_cnt_q;

    if (redirect) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      if (redirect_bad) begin
        halted_d    = 1'b1;
        align_err_d = 1'b1;
      end else begin
        fetch_pc_d  = target_pc;
        halted_d    = 1'b0;
        align_err_d = 1'b0;
      end
    end else begin
      if (out_of_range) begin
        halted_d = 1'b1;
      end
      if (pop) begin
        head_d = ptr_inc(head_q);
      end
      if (push) begin
        tail_d      = ptr_inc(tail_q);
        fetch_pc_d  = fetch_pc_q + 64'd4;
        fetch_cnt_d = fetch_cnt_q + 32'd1;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q  <= RESET_PC;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      halted_q    <= 1'b0;
      align_err_q <= 1'b0;
      fetch_cnt_q <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      halted_q    <= halted_d;
      align_err_q <= align_err_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  // Queue payload needs no reset: entries are only visible while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      q_mem[tail_q] <= '{pc: fetch_pc_q, instr: imem_instr};
    end
  end

  assign imem_addr = fetch_pc_q;
  assign out_pc    = q_mem[head_q].pc;
  assign out_instr = q_mem[head_q].instr;
  assign halted    = halted_q;
  assign align_err = align_err_q;
  assign fetch_cnt = fetch_cnt_q;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset) begin
      assert (count_q <= CNT_W'(QDEPTH));
    end
  end
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_imem_fetch_ctrl;

  localparam int unsigned MEM_BYTES = 1024;
  localparam int unsigned QDEPTH    = 2;
  localparam logic [63:0] RESET_PC  = 64'd0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        halted;
  logic        align_err;
  logic [31:0] fetch_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [63:0] a);
    return 32'hDEAD_0000 ^ (a[31:0] * 32'd2654435761);
  endfunction

  assign imem_instr = rom(imem_addr);

  imem_fetch_ctrl #(
    .MEM_BYTES(MEM_BYTES),
    .RESET_PC (RESET_PC),
    .QDEPTH   (QDEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_addr  (imem_addr),
    .imem_instr (imem_instr),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_pc     (out_pc),
    .halted     (halted),
    .align_err  (align_err),
    .fetch_cnt  (fetch_cnt)
  );

  // Reference model: a plain queue of fetched (pc, instr) pairs plus fetch pointer and flags.
  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  logic [63:0] m_fpc;
  bit          m_halt;
  bit          m_aerr;
  logic [31:0] m_cnt;

  task automatic model_reset();
    mq.delete();
    m_fpc  = RESET_PC;
    m_halt = 1'b0;
    m_aerr = 1'b0;
    m_cnt  = 32'd0;
  endtask

  task automatic model_step(input bit rd, input logic [63:0] rpc, input bit rdy);
    bit   is_bad;
    bit   fits;
    bit   do_pop;
    bit   do_push;
    ent_t e;
    if (rd) begin
      mq.delete();
`ifdef FETCH_ALIGN_CHECK_EN
      is_bad = (rpc % 4 != 0) || (rpc + 3 >= 64'(MEM_BYTES));
`else
      is_bad = 1'b0;
`endif
      if (is_bad) begin
        m_halt = 1'b1;
        m_aerr = 1'b1;
      end else begin
        m_fpc  = rpc - (rpc % 4);
        m_halt = 1'b0;
        m_aerr = 1'b0;
      end
    end else begin
      fits    = (m_fpc < 64'(MEM_BYTES)) && (64'(MEM_BYTES) - m_fpc > 64'd3);
      do_pop  = (mq.size() > 0) && rdy;
      do_push = !m_halt && fits && ((mq.size() < QDEPTH) || do_pop);
      if (!fits) m_halt = 1'b1;
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        e.pc    = m_fpc;
        e.instr = rom(m_fpc);
        mq.push_back(e);
        m_fpc = m_fpc + 64'd4;
        m_cnt = m_cnt + 32'd1;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("valid", 64'(out_valid), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("out_pc", out_pc, mq[0].pc);
      chk("out_instr", 64'(out_instr), 64'(mq[0].instr));
    end
    chk("halted", 64'(halted), 64'(m_halt));
    chk("align_err", 64'(align_err), 64'(m_aerr));
    chk("fetch_cnt", 64'(fetch_cnt), 64'(m_cnt));
    if (!m_aerr) chk("imem_addr", imem_addr, m_fpc);
  endtask

  task automatic cycle(input bit rd, input logic [63:0] rpc, input bit rdy);
    redirect    = rd;
    redirect_pc = rpc;
    out_ready   = rdy;
    @(posedge clk);
    model_step(rd, rpc, rdy);
    #1;
    compare_all();
    redirect = 1'b0;
  endtask

  task automatic do_reset();
    redirect  = 1'b0;
    out_ready = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    model_reset();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_cnt", 64'(fetch_cnt), 64'd0);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_aerr", 64'(align_err), 64'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    bit          rd;
    logic [63:0] rpc;
    bit          rdy;
    bit          ev;
    logic [63:0] epc;
    logic [31:0] ecnt;
    logic [63:0] eaddr;
  } vec_t;

  vec_t tbl[10];

  logic [63:0] last_pc;
  logic [63:0] tgt;

  initial begin
    // Fill, stall, resume, then redirect to 0x40 with a full queue.
    tbl[0] = '{1'b0, 64'h0,  1'b0, 1'b1, 64'h0,  32'd1, 64'h4};
    tbl[1] = '{1'b0, 64'h0,  1'b0, 1'b1, 64'h0,  32'd2, 64'h8};
    tbl[2] = '{1'b0, 64'h0,  1'b0, 1'b1, 64'h0,  32'd2, 64'h8};
    tbl[3] = '{1'b0, 64'h0,  1'b0, 1'b1, 64'h0,  32'd2, 64'h8};
    tbl[4] = '{1'b0, 64'h0,  1'b0, 1'b1, 64'h0,  32'd2, 64'h8};
    tbl[5] = '{1'b0, 64'h0,  1'b1, 1'b1, 64'h4,  32'd3, 64'hC};
    tbl[6] = '{1'b0, 64'h0,  1'b1, 1'b1, 64'h8,  32'd4, 64'h10};
    tbl[7] = '{1'b1, 64'h40, 1'b1, 1'b0, 64'h0,  32'd4, 64'h40};
    tbl[8] = '{1'b0, 64'h0,  1'b1, 1'b1, 64'h40, 32'd5, 64'h44};
    tbl[9] = '{1'b0, 64'h0,  1'b1, 1'b1, 64'h44, 32'd6, 64'h48};

    redirect    = 1'b0;
    redirect_pc = 64'd0;
    out_ready   = 1'b0;
    #2;
    do_reset();

    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].rd, tbl[i].rpc, tbl[i].rdy);
      chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(tbl[i].ev));
      if (tbl[i].ev) chk($sformatf("tbl%0d_pc", i), out_pc, tbl[i].epc);
      chk($sformatf("tbl%0d_cnt", i), 64'(fetch_cnt), 64'(tbl[i].ecnt));
      chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].eaddr);
    end

    // Reset asserted mid-stream with two entries queued.
    cycle(1'b0, 64'h0, 1'b0);
    cycle(1'b0, 64'h0, 1'b0);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_cnt", 64'(fetch_cnt), 64'd0);
    chk("mid_rst_addr", imem_addr, RESET_PC);
    @(negedge clk);
    reset = 1'b0;
    cycle(1'b0, 64'h0, 1'b1);
    chk("restart_pc", out_pc, RESET_PC);
    chk("restart_cnt", 64'(fetch_cnt), 64'd1);

    // Run off the end of memory, drain, then recover with a redirect.
    cycle(1'b1, 64'h3F0, 1'b1);
    last_pc = 64'h0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 64'h0, 1'b1);
      if (out_valid) last_pc = out_pc;
    end
    chk("end_halted", 64'(halted), 64'd1);
    chk("end_drained", 64'(out_valid), 64'd0);
    chk("end_last_pc", last_pc, 64'h3FC);
    cycle(1'b1, 64'h0, 1'b1);
    chk("recover_halted", 64'(halted), 64'd0);
    cycle(1'b0, 64'h0, 1'b1);
    chk("recover_pc", out_pc, 64'h0);

    // Misaligned redirect target.
    cycle(1'b1, 64'h42, 1'b1);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("bad_aerr", 64'(align_err), 64'd1);
    chk("bad_halted", 64'(halted), 64'd1);
    chk("bad_valid", 64'(out_valid), 64'd0);
    cycle(1'b0, 64'h0, 1'b1);
    cycle(1'b1, 64'h10, 1'b1);
    chk("good_aerr", 64'(align_err), 64'd0);
    cycle(1'b0, 64'h0, 1'b1);
    chk("good_pc", out_pc, 64'h10);
`else
    chk("mask_aerr", 64'(align_err), 64'd0);
    cycle(1'b0, 64'h0, 1'b1);
    chk("mask_pc", out_pc, 64'h40);
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      tgt = 64'($urandom_range(0, MEM_BYTES + 31));
      if ($urandom_range(0, 3) == 0) tgt = 64'(MEM_BYTES - 24 + $urandom_range(0, 31));
      if ($urandom_range(0, 3) != 0) tgt = tgt - (tgt % 4);
      cycle($urandom_range(0, 9) == 0, tgt, $urandom_range(0, 2) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 1024, instruction ROM size in bytes (power of two, >4).
REQ-002 SHALL have parameter RESET_PC, default 64'd0, first fetch address after reset.
REQ-003 SHALL have parameter QDEPTH, default 2, fetch queue entries (>=2).
REQ-004 SHALL have port clk  input  1  single clock, all state on posedge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port imem_addr  output  64  byte address driven to the combinational instruction ROM.
REQ-007 SHALL have port imem_instr  input  32  ROM read data for imem_addr, valid same cycle.
REQ-008 SHALL have port redirect  input  1  one-cycle branch/flush request.
REQ-009 SHALL have port redirect_pc  input  64  new fetch address, sampled when redirect=1.
REQ-010 SHALL have port out_valid  output  1  queue head holds a valid instruction.
REQ-011 SHALL have port out_ready  input  1  consumer accepts head this cycle.
REQ-012 SHALL have port out_instr  output  32  head instruction.
REQ-013 SHALL have port out_pc  output  64  head instruction address.
REQ-014 SHALL have port halted  output  1  fetch stopped at end of memory or on error.
REQ-015 SHALL have port align_err  output  1  sticky bad-redirect flag.
REQ-016 SHALL have port fetch_cnt  output  32  number of queue pushes, wraps modulo 2^32.

Function
REQ-017 SHALL hold fetch_pc register; imem_addr = fetch_pc combinationally.
REQ-018 SHALL push {fetch_pc, imem_instr} and advance fetch_pc by 4 on an edge when: not halted, no redirect, and (count<QDEPTH or pop this cycle).
REQ-019 SHALL pop on an edge when out_valid & out_ready & !redirect; simultaneous push+pop on a full queue keeps count unchanged.
REQ-020 SHALL drive out_valid = (count!=0); out_instr/out_pc from head; FIFO order preserved.
REQ-021 SHALL on redirect: flush queue (count<=0), fetch_pc<=redirect_pc, clear halted, no push/pop that edge; redirect wins over any simultaneous pop.
REQ-022 SHALL give redirect-to-out_valid latency of 2 cycles: redirect in cycle N, queue empty in N+1, target instruction at head in N+2.
REQ-023 SHALL set halted and stop pushing when fetch_pc+3 >= MEM_BYTES; queued entries still drain; only redirect or reset leaves halted. No address wrap-around.
REQ-024 SHALL increment fetch_cnt by 1 on every push, never on flush or pop.
REQ-025 SHALL hold all state when out_ready=0 and queue full (stall), imem_addr stable.

Reset
REQ-026 SHALL on reset asynchronously set fetch_pc=RESET_PC, count=0, halted=0, align_err=0, fetch_cnt=0; out_valid=0 during reset.
REQ-027 SHALL push RESET_PC instruction on first edge after reset deasserts; out_valid=1 from the following cycle.
REQ-028 SHALL abandon any in-progress state on reset mid-operation; no residual queue entries.

Configuration
REQ-029 SHALL support macro FETCH_ALIGN_CHECK_EN.
REQ-030 With FETCH_ALIGN_CHECK_EN defined: redirect_pc[1:0]!=0 or redirect_pc+3>=MEM_BYTES flushes queue, sets halted and align_err; align_err clears only on a later valid redirect or reset.
REQ-031 Without FETCH_ALIGN_CHECK_EN: redirect_pc[1:0] masked to 0, align_err tied 0, out-of-range target handled by REQ-023.

Verification
REQ-032 Reset release, out_ready=1 -> out_pc 0,4,8,... one per cycle from cycle 1, fetch_cnt=N after N edges.
REQ-033 out_ready=0 for 5 cycles -> count saturates at QDEPTH=2, imem_addr holds 8, fetch_cnt=2; resume -> pcs 0,4,8 in order, no loss/duplication.
REQ-034 redirect with redirect_pc=0x40 while queue full and out_ready=1 -> out_valid 0 next cycle, out_pc=0x40 two cycles after redirect, no pop counted.
REQ-035 Sequential fetch to 0x3FC (MEM_BYTES=1024) -> halted=1, final out_pc 0x3FC, queue drains; redirect 0x0 -> halted=0, fetching resumes.
REQ-036 FETCH_ALIGN_CHECK_EN: redirect_pc=0x42 -> align_err=1, halted=1, out_valid=0; redirect 0x10 -> align_err=0, out_pc=0x10 two cycles later; macro off: 0x42 fetches 0x40.
REQ-037 Assert reset mid-stream with 2 entries queued -> out_valid=0, fetch_cnt=0 immediately; restart at RESET_PC.
